// File: rtl/qamtheta.sv
// 16-QAM symbol mapper: deserialises 4 bits per symbol into Gray-coded I/Q pairs and scales cos/sin by +-1/+-3.
// Latency: symbol registers load on the 4th bit edge, products follow one edge later; no backpressure, accepts one bit every clock.
module qamtheta (
   input  logic        clk_16,
   input  logic        rst,
   input  logic        inputsignal,
   input  logic [11:0] cos,
   input  logic [11:0] sin,
   output logic [15:0] acos,
   output logic [15:0] bsin,
   output logic [1:0]  bitsa,
   output logic [1:0]  bitsb
);

   logic [2:0]  bit_hist;
   logic [3:0]  sym_window;
   logic [1:0]  bit_cnt;
   logic        valid;
   logic [15:0] a_prod;
   logic [15:0] b_prod;

   // Gray amplitude times carrier: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3
   function automatic logic [15:0] gray_scale(input logic [1:0] pair, input logic [11:0] x);
      logic [15:0] x1;
      logic [15:0] x3;
      x1 = {{4{x[11]}}, x};
      x3 = (x1 << 1) + x1;
      case (pair)
         2'b00:   gray_scale = -x3;
         2'b01:   gray_scale = -x1;
         2'b11:   gray_scale = x1;
         default: gray_scale = x3;
      endcase
   endfunction

   // Full 4-bit shift window; the oldest bit only ever leaves through the symbol load.
   assign sym_window = {bit_hist, inputsignal};

   always_comb begin
      a_prod = gray_scale(bitsa, cos);
      b_prod = gray_scale(bitsb, sin);
   end

   always_ff @(posedge clk_16) begin
      if (rst) begin
         bit_hist <= 3'b000;
         bit_cnt  <= 2'd0;
         valid    <= 1'b0;
         bitsa    <= 2'b00;
         bitsb    <= 2'b00;
         acos     <= 16'd0;
         bsin     <= 16'd0;
      end else begin
         bit_hist <= sym_window[2:0];
         bit_cnt  <= bit_cnt + 2'd1;
         if (bit_cnt == 2'd3) begin
            bitsa <= sym_window[3:2];
            bitsb <= sym_window[1:0];
            valid <= 1'b1;
         end
         acos <= valid ? a_prod : 16'd0;
         bsin <= valid ? b_prod : 16'd0;
      end
   end

endmodule

// File: tb/tb_qamtheta.sv
// Bench for qamtheta: directed literal cases plus random bits/carriers against a per-symbol arithmetic model.
module tb_qamtheta;

   logic        clk_16 = 1'b0;
   logic        rst = 1'b1;
   logic        inputsignal = 1'b0;
   logic [11:0] cos_i = 12'd0;
   logic [11:0] sin_i = 12'd0;
   logic [15:0] acos;
   logic [15:0] bsin;
   logic [1:0]  bitsa;
   logic [1:0]  bitsb;

   int n_cmp  = 0;
   int n_fail = 0;

   qamtheta dut (
      .clk_16      (clk_16),
      .rst         (rst),
      .inputsignal (inputsignal),
      .cos         (cos_i),
      .sin         (sin_i),
      .acos        (acos),
      .bsin        (bsin),
      .bitsa       (bitsa),
      .bitsb       (bitsb)
   );

   always #5 clk_16 = ~clk_16;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int amp(input logic [1:0] p);
      case (p)
         2'b00:   return -3;
         2'b01:   return -1;
         2'b11:   return 1;
         default: return 3;
      endcase
   endfunction

   // Reference model: count bits since reset, collect each group of four, and
   // form products from the symbol held before the edge and the carrier at the edge.
   int         m_k = 0;
   logic [0:3] m_sym = 4'b0000;
   logic [1:0] m_a = 2'b00;
   logic [1:0] m_b = 2'b00;
   int         m_acos = 0;
   int         m_bsin = 0;
   bit         m_live = 1'b0;

   always @(posedge clk_16) begin
      logic r;
      logic b;
      logic [11:0] c;
      logic [11:0] s;
      r = rst;
      b = inputsignal;
      c = cos_i;
      s = sin_i;
      if (r) begin
         m_live = 1'b1;
         m_k    = 0;
         m_a    = 2'b00;
         m_b    = 2'b00;
         m_acos = 0;
         m_bsin = 0;
      end else begin
         if (m_k >= 4) begin
            m_acos = amp(m_a) * int'($signed(c));
            m_bsin = amp(m_b) * int'($signed(s));
         end else begin
            m_acos = 0;
            m_bsin = 0;
         end
         m_sym[m_k % 4] = b;
         m_k++;
         if (m_k % 4 == 0) begin
            m_a = {m_sym[0], m_sym[1]};
            m_b = {m_sym[2], m_sym[3]};
         end
      end
      #1;
      if (m_live) begin
         chk("model_bitsa", int'(bitsa), int'(m_a));
         chk("model_bitsb", int'(bitsb), int'(m_b));
         chk("model_acos", int'($signed(acos)), m_acos);
         chk("model_bsin", int'($signed(bsin)), m_bsin);
      end
   end

   // One clock: drive on the falling edge, return shortly after the rising edge.
   task automatic step(input logic r, input logic b, input int c, input int s);
      @(negedge clk_16);
      rst         = r;
      inputsignal = b;
      cos_i       = c[11:0];
      sin_i       = s[11:0];
      @(posedge clk_16);
      #2;
   endtask

   task automatic send4(input logic [3:0] bits, input int c, input int s);
      for (int i = 3; i >= 0; i--) step(1'b0, bits[i], c, s);
   endtask

   initial begin
      // Reset then idle
      step(1'b1, 1'b0, 1025, -8);
      step(1'b1, 1'b0, 1025, -8);
      chk("rst_bitsa", int'(bitsa), 0);
      chk("rst_bitsb", int'(bitsb), 0);
      chk("rst_acos", int'(acos), 0);
      chk("rst_bsin", int'(bsin), 0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1025, -8);
      chk("pre_symbol_acos", int'(acos), 0);
      chk("pre_symbol_bitsa", int'(bitsa), 0);

      // Bits 1,0,1,1
      step(1'b1, 1'b0, 1025, -8);
      send4(4'b1011, 1025, -8);
      chk("s1011_bitsa", int'(bitsa), 2);
      chk("s1011_bitsb", int'(bitsb), 3);
      chk("s1011_acos_still0", int'(acos), 0);
      step(1'b0, 1'b0, 1025, -8);
      chk("s1011_acos", int'(acos), 16'h0C03);
      chk("s1011_bsin", int'(bsin), 16'hFFF8);

      // Bits 0,0,0,0
      step(1'b1, 1'b0, 0, 0);
      send4(4'b0000, 1025, -8);
      step(1'b0, 1'b0, 1025, -8);
      chk("s0000_acos", int'(acos), 16'hF3FD);
      chk("s0000_bsin", int'(bsin), 16'h0018);

      // Extremes with bitsa = 00, bitsb = 01
      step(1'b1, 1'b0, 0, 0);
      send4(4'b0001, 0, 0);
      step(1'b0, 1'b0, -2048, -2048);
      chk("ext_acos_neg", int'(acos), 16'h1800);
      chk("ext_bsin_neg", int'(bsin), 16'h0800);
      step(1'b0, 1'b0, 2047, -2048);
      chk("ext_acos_pos", int'(acos), 16'hE803);

      // Held symbol, changing carrier
      step(1'b1, 1'b0, 0, 0);
      send4(4'b0111, 0, 0);
      step(1'b0, 1'b0, 100, 0);
      chk("held_acos_100", int'($signed(acos)), -100);
      chk("held_bitsa_1", int'(bitsa), 1);
      step(1'b0, 1'b0, 200, 0);
      chk("held_acos_200", int'($signed(acos)), -200);
      step(1'b0, 1'b0, 200, 0);
      chk("held_bitsa_3", int'(bitsa), 1);

      // Reset mid-symbol discards the partial bits
      step(1'b1, 1'b0, 0, 0);
      step(1'b0, 1'b1, 300, -50);
      step(1'b0, 1'b1, 300, -50);
      step(1'b1, 1'b1, 300, -50);
      send4(4'b0110, 300, -50);
      chk("midrst_bitsa", int'(bitsa), 1);
      chk("midrst_bitsb", int'(bitsb), 2);
      step(1'b0, 1'b0, 300, -50);
      chk("midrst_acos", int'($signed(acos)), -300);
      chk("midrst_bsin", int'($signed(bsin)), -150);

      // Reset on the 4th bit edge must win over the symbol load
      step(1'b1, 1'b0, 0, 0);
      send4(4'b1111, 0, 0);
      step(1'b0, 1'b0, 0, 0);
      step(1'b0, 1'b0, 0, 0);
      step(1'b0, 1'b0, 0, 0);
      step(1'b1, 1'b0, 500, 500);
      chk("rst_boundary_bitsa", int'(bitsa), 0);
      chk("rst_boundary_acos", int'(acos), 0);

      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 59) == 0), 1'($urandom()),
              int'($urandom_range(0, 4095)) - 2048,
              int'($urandom_range(0, 4095)) - 2048);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
